multiplicador_seq_ctrl: RTL and testbench

Sequential shift-and-add controller for an unsigned WIDTH x WIDTH multiply. It time-shares one external partial-product generator (A AND-ed with a single bit B_i) over WIDTH cycles. It drives A and one multiplier bit per cycle and accumulates the returned partial product, shifted, into a 2*WIDTH-bit result. It sits between the operand registers and the result bus and replaces the WIDTH-instance combinational array when area matters.

---
 rtl/multiplicador_seq_ctrl_if.sv | 39 +++
 rtl/multiplicador_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_multiplicador_seq_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multiplicador_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multiplicador_seq_ctrl_if
// Purpose  : Bundles the operand/request, partial-product generator and
//            result signals of the sequential shift-and-add multiplier
//            controller.
// Signals  : start, A, B          request and operands (towards controller)
//            pp_a, pp_b_i         operands for the external AND-array
//            pp_out               partial product returned (same cycle)
//            busy, done, produto  status and 2*WIDTH-bit result
// Modports : slave  - the controller itself
//            master - the environment (operand source + PP generator + sink)
// Revision : 1.0 - initial release
// ============================================================================
interface multiplicador_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [WIDTH-1:0]       pp_a;
    logic                   pp_b_i;
    logic [WIDTH-1:0]       pp_out;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     produto;

    modport slave (
        input  start, A, B, pp_out,
        output pp_a, pp_b_i, busy, done, produto
    );

    modport master (
        output start, A, B, pp_out,
        input  pp_a, pp_b_i, busy, done, produto
    );
endinterface
`default_nettype wire

// File: rtl/multiplicador_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multiplicador_seq_ctrl
// Purpose  : Sequential unsigned WIDTH x WIDTH shift-and-add multiplier
//            controller. One external partial-product generator (A AND B_i)
//            is time-shared over up to WIDTH cycles; each returned partial
//            product is shifted by the bit index and added into a 2*WIDTH-bit
//            accumulator. FSM: IDLE -> CALC -> FIM -> IDLE.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - multiplicador_seq_ctrl_if.slave (start, A, B, pp_a,
//                   pp_b_i, pp_out, busy, done, produto)
// Options  : MULT_EARLY_TERM_EN - when defined, CALC ends as soon as no set
//            multiplier bit remains above the current index. Results are
//            identical; only latency differs.
// Revision : 1.0 - initial release
// ============================================================================
module multiplicador_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire                      clk,
    input  wire                      rst,
    multiplicador_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIM  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_acc;
    logic [PW-1:0]       r_produto;
    // Multiplier bits above the one currently on pp_b_i; shifted down each
    // CALC cycle so the next bit is always r_b_hi[0].
    logic [WIDTH-1:0]    r_b_hi;
    // Registered generator operands double as the captured multiplicand
    // and the current multiplier bit (reg_a / reg_b[cnt]).
    logic [WIDTH-1:0]    r_pp_a;
    logic                r_pp_b;
    logic                r_busy;
    logic                r_done;

    logic [PW-1:0]       w_pp_ext;
    logic [PW-1:0]       w_sum;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_last;

    assign w_pp_ext  = {{WIDTH{1'b0}}, bus.pp_out} << r_cnt;
    assign w_sum     = r_acc + w_pp_ext;
    assign w_cnt_nxt = r_cnt + CW'(1);

`ifdef MULT_EARLY_TERM_EN
    // Stop once the remaining upper multiplier bits are all zero.
    assign w_last = (r_cnt == CW'(WIDTH - 1)) || (r_b_hi == '0);
`else
    assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_produto <= '0;
            r_b_hi    <= '0;
            r_pp_a    <= '0;
            r_pp_b    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_pp_a  <= bus.A;
                        r_pp_b  <= bus.B[0];
                        r_b_hi  <= bus.B >> 1;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc  <= w_sum;
                    r_cnt  <= w_cnt_nxt;
                    r_b_hi <= r_b_hi >> 1;
                    if (w_last) begin
                        // Final accumulation goes straight to the result.
                        r_produto <= w_sum;
                        r_pp_a    <= '0;
                        r_pp_b    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FIM;
                    end else begin
                        r_pp_b <= r_b_hi[0];
                    end
                end
                S_FIM: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pp_a  <= '0;
                    r_pp_b  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pp_a    = r_pp_a;
    assign bus.pp_b_i  = r_pp_b;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.produto = r_produto;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multiplicador_seq_ctrl
// Purpose  : Scoreboard bench for multiplicador_seq_ctrl (WIDTH=4). Stimulus
//            pushes the expected product and done cycle; a negedge monitor
//            pops and compares whenever done is seen. Honours
//            MULT_EARLY_TERM_EN for expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplicador_seq_ctrl;
    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplicador_seq_ctrl_if #(.WIDTH(W)) bus ();

    multiplicador_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External partial-product generator: A AND B_i.
    assign bus.pp_out = bus.pp_b_i ? bus.pp_a : '0;

    typedef struct {
        logic [PW-1:0] prod;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int lat_of(input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        int l = 1;
        for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
        return l;
`else
        return W;
`endif
    endfunction

    // Monitor: checks product and exact done cycle against the scoreboard.
    always @(negedge clk) begin
        if (bus.done) begin
            chk("done_single_pulse", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("produto", 64'(bus.produto), 64'(e.prod));
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
        prev_done <= bus.done;
    end

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 64'(bus.done), 64'd1);
    endtask

    // Issue one multiply from IDLE (called at a negedge), push expectation,
    // scramble A/B after acceptance, wait for done, return in IDLE.
    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] p);
        exp_t e;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        e.prod    = p;
        e.due     = cyc + 1 + lat_of(b);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] seq;
        exp_t         e;
        int           n;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        chk("rst_produto", 64'(bus.produto), 64'd0);
        chk("rst_busy",    64'(bus.busy),    64'd0);
        chk("rst_done",    64'(bus.done),    64'd0);
        chk("rst_pp_a",    64'(bus.pp_a),    64'd0);
        chk("rst_pp_b_i",  64'(bus.pp_b_i),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 13 x 11: multiplier bit sequence 1,1,0,1 over four busy cycles.
        seq       = 4'b1011;
        bus.start = 1'b1;
        bus.A     = 4'd13;
        bus.B     = 4'd11;
        e.prod    = 8'd143;
        e.due     = cyc + 1 + lat_of(4'd11);
        sb.push_back(e);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.A     = 4'd2;
            bus.B     = 4'd2;
            chk("calc_busy",   64'(bus.busy),   64'd1);
            chk("calc_pp_a",   64'(bus.pp_a),   64'd13);
            chk("calc_pp_b_i", 64'(bus.pp_b_i), 64'(seq[i]));
        end
        @(negedge clk);
        chk("fim_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("produto_hold", 64'(bus.produto), 64'd143);

        mul(4'd15, 4'd15, 8'd225);
        mul(4'd0,  4'd9,  8'd0);
        mul(4'd7,  4'd1,  8'd7);
        mul(4'd9,  4'd0,  8'd0);
        mul(4'd5,  4'd8,  8'd40);
        mul(4'd6,  4'd10, 8'd60);

        // start held high: only captured operands count; FIM ignores start.
        bus.start = 1'b1;
        bus.A     = 4'd2;
        bus.B     = 4'd3;
        e.prod    = 8'd6;
        e.due     = cyc + 1 + lat_of(4'd3);
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 20) begin
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            @(negedge clk);
            n++;
        end
        chk("held_done_timeout", 64'(bus.done), 64'd1);
        bus.A  = 4'd5;
        bus.B  = 4'd4;
        e.prod = 8'd20;
        e.due  = cyc + 2 + lat_of(4'd4);
        sb.push_back(e);
        @(negedge clk);
        chk("idle_not_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        @(negedge clk);

        // Reset during the second CALC cycle of 7 x 6 discards the result.
        bus.start = 1'b1;
        bus.A     = 4'd7;
        bus.B     = 4'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_produto", 64'(bus.produto), 64'd0);
        chk("abort_busy",    64'(bus.busy),    64'd0);
        chk("abort_done",    64'(bus.done),    64'd0);
        chk("abort_pp_a",    64'(bus.pp_a),    64'd0);
        chk("abort_pp_b_i",  64'(bus.pp_b_i),  64'd0);
        @(negedge clk);
        mul(4'd3, 4'd5, 8'd15);

        // Exhaustive sweep against the reference product.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                mul(W'(a), W'(b), PW'(a * b));
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
